huff_decoder: RTL

Downstream companion to the Huffman encoder. It loads the three-entry code table that the encoder streams out as alternating character and code words. It then takes a serial code bitstream, one bit per valid cycle, and emits the decoded 5-bit characters. Both ports use the same 12-bit io_in/io_out pin budget as the encoder.

---
 rtl/huff_decoder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/huff_decoder.sv
// Huffman table loader and serial code decoder: loads three char/code entries, then decodes an MSB-first bitstream.
// Optional HUFF_DEC_COUNT_EN builds a 4-bit sym_valid counter on io_out[8:5]; otherwise those bits are 0.
module huff_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] io_in,
    output logic [11:0] io_out
);

    localparam logic [1:0] LOAD_CHAR = 2'd0;
    localparam logic [1:0] LOAD_CODE = 2'd1;
    localparam logic [1:0] DECODE    = 2'd2;

    logic [1:0] state;
    logic [1:0] idx;
    logic [4:0] char_tab  [3];
    logic [2:0] mask_tab  [3];
    logic [2:0] value_tab [3];
    logic [1:0] len_tab   [3];
    logic [2:0] acc;
    logic [1:0] bitcnt;

    logic       sym_valid;
    logic       err;
    logic       table_ready;
    logic [4:0] char_out;
    logic [3:0] sym_count;

    logic       in_valid;
    logic       mode;
    logic       clear;
    logic       bit_in;
    logic       is_char_word;
    logic       is_code_word;
    logic       unused_done;

    assign in_valid     = io_in[11];
    assign mode         = io_in[10];
    assign clear        = in_valid & io_in[9];
    assign bit_in       = io_in[0];
    assign is_char_word = (io_in[7:5] == 3'b011);
    assign is_code_word = (io_in[7:6] == 2'b00);
    assign unused_done  = io_in[8];

    // Only contiguous low-aligned masks are legal; anything else never matches.
    function automatic logic [1:0] mask_len(input logic [2:0] m);
        case (m)
            3'b001:  mask_len = 2'd1;
            3'b011:  mask_len = 2'd2;
            3'b111:  mask_len = 2'd3;
            default: mask_len = 2'd0;
        endcase
    endfunction

    logic [2:0] acc_next;
    logic [1:0] cnt_next;
    logic       hit;
    logic [4:0] hit_char;
    logic       bit_take;
    logic       sym_fire;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        acc_next = {acc[1:0], bit_in};
        cnt_next = bitcnt + 2'd1;
        hit      = 1'b0;
        hit_char = 5'd0;
        for (int i = 0; i < 3; i++) begin
            if (!hit && len_tab[i] != 2'd0 && len_tab[i] == cnt_next &&
                (acc_next & mask_tab[i]) == (value_tab[i] & mask_tab[i])) begin
                hit      = 1'b1;
                hit_char = char_tab[i];
            end
        end
    end

    assign bit_take = in_valid & mode & ~clear & (state == DECODE);
    assign sym_fire = bit_take & hit;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOAD_CHAR;
            idx         <= 2'd0;
            acc         <= 3'd0;
            bitcnt      <= 2'd0;
            sym_valid   <= 1'b0;
            err         <= 1'b0;
            table_ready <= 1'b0;
            char_out    <= 5'd0;
            // NOTE: the table is only three entries and must read as zero after reset, so it is reset like any flop.
            for (int i = 0; i < 3; i++) begin
                char_tab[i]  <= 5'd0;
                mask_tab[i]  <= 3'd0;
                value_tab[i] <= 3'd0;
                len_tab[i]   <= 2'd0;
            end
        end else begin
            sym_valid <= 1'b0;
            err       <= 1'b0;
            if (clear) begin
                state       <= LOAD_CHAR;
                idx         <= 2'd0;
                acc         <= 3'd0;
                bitcnt      <= 2'd0;
                table_ready <= 1'b0;
                for (int i = 0; i < 3; i++) begin
                    char_tab[i]  <= 5'd0;
                    mask_tab[i]  <= 3'd0;
                    value_tab[i] <= 3'd0;
                    len_tab[i]   <= 2'd0;
                end
            end else if (in_valid) begin
                case (state)
                    LOAD_CHAR: begin
                        if (!mode && is_char_word) begin
                            char_tab[idx] <= io_in[4:0];
                            state         <= LOAD_CODE;
                        end
                    end
                    LOAD_CODE: begin
                        if (!mode && is_code_word) begin
                            mask_tab[idx]  <= io_in[5:3];
                            value_tab[idx] <= io_in[2:0];
                            len_tab[idx]   <= mask_len(io_in[5:3]);
                            if (idx == 2'd2) begin
                                state       <= DECODE;
                                table_ready <= 1'b1;
                            end else begin
                                idx   <= idx + 2'd1;
                                state <= LOAD_CHAR;
                            end
                        end else if (!mode && is_char_word) begin
                            char_tab[idx] <= io_in[4:0];
                        end
                    end
                    DECODE: begin
                        if (mode) begin
                            if (hit) begin
                                char_out  <= hit_char;
                                sym_valid <= 1'b1;
                                acc       <= 3'd0;
                                bitcnt    <= 2'd0;
                            end else if (cnt_next == 2'd3) begin
                                err    <= 1'b1;
                                acc    <= 3'd0;
                                bitcnt <= 2'd0;
                            end else begin
                                acc    <= acc_next;
                                bitcnt <= cnt_next;
                            end
                        end
                    end
                    default: state <= LOAD_CHAR;
                endcase
            end
        end
    end

`ifdef HUFF_DEC_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sym_count <= 4'd0;
        end else if (sym_fire) begin
            sym_count <= sym_count + 4'd1;
        end
    end
`else
    logic unused_fire;
    assign unused_fire = sym_fire;
    assign sym_count   = 4'd0;
`endif

    assign io_out = {sym_valid, err, table_ready, sym_count, char_out};

endmodule
